pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives hold, bubble and flush

---
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline datapath and the hazard sequencer.
// Combinational signals only; clock and reset are wired to the controller separately.
// The master side is the pipeline, which drives hazard inputs and receives stage controls.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       IF_ID_RegRs_i;
   logic [4:0]       IF_ID_RegRt_i;
   logic             ID_EX_MemRead_i;
   logic [4:0]       ID_EX_RegRt_i;
   logic             Branch_taken_i;
   logic             Mem_req_i;
   logic             Mem_ack_i;
   logic             PC_write_o;
   logic             IF_ID_write_o;
   logic             IF_ID_flush_o;
   logic             ID_EX_stall_o;
   logic             ID_EX_bubble_o;
   logic             EX_MEM_stall_o;
   logic             MEM_WB_bubble_o;
   logic [CNT_W-1:0] Stall_count_o;
   logic             Timeout_err_o;

   modport master (
      output IF_ID_RegRs_i, IF_ID_RegRt_i, ID_EX_MemRead_i, ID_EX_RegRt_i,
             Branch_taken_i, Mem_req_i, Mem_ack_i,
      input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_stall_o,
             ID_EX_bubble_o, EX_MEM_stall_o, MEM_WB_bubble_o, Stall_count_o,
             Timeout_err_o
   );

   modport slave (
      input  IF_ID_RegRs_i, IF_ID_RegRt_i, ID_EX_MemRead_i, ID_EX_RegRt_i,
             Branch_taken_i, Mem_req_i, Mem_ack_i,
      output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_stall_o,
             ID_EX_bubble_o, EX_MEM_stall_o, MEM_WB_bubble_o, Stall_count_o,
             Timeout_err_o
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, taken-branch flushes, data-memory wait with watchdog.
// Latency: stage controls are combinational (same cycle); state, counters and error are registered.
// Backpressure: an outstanding memory access without ack freezes every stage; ERROR freezes forever.
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic                   Clock_i,
   input  logic                   Reset_n_i,
   pipeline_hazard_ctrl_if.slave  hz
);
   localparam int WC_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              err_q, err_d;

   logic mem_pend;
   logic freeze;
   logic load_use;
   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_stall;
   logic id_ex_bubble;
   logic ex_mem_stall;
   logic mem_wb_bubble;

   // A zero-wait access (req and ack together) never freezes; ack alone is ignored.
   assign mem_pend = hz.Mem_req_i & ~hz.Mem_ack_i;
   assign freeze   = (state_q == ERROR) | mem_pend;
   // r0 is hardwired zero, so a load into it never creates a dependency.
   assign load_use = hz.ID_EX_MemRead_i & (hz.ID_EX_RegRt_i != 5'd0) &
                     ((hz.ID_EX_RegRt_i == hz.IF_ID_RegRs_i) |
                      (hz.ID_EX_RegRt_i == hz.IF_ID_RegRt_i));

   // Stage controls by priority: reset/freeze, then load-use bubble, then branch flush.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_stall   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_stall  = 1'b0;
      mem_wb_bubble = 1'b0;
      if (!Reset_n_i || freeze) begin
         // Freeze suppresses bubble/flush; hazards are re-evaluated once released.
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_stall   = 1'b1;
         ex_mem_stall  = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (load_use) begin
         // A taken branch in the same cycle re-resolves next cycle, so no flush yet.
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (hz.Branch_taken_i) begin
         if_id_flush = 1'b1;
      end
   end

   // Memory-wait sequencing, watchdog and saturating stall counter.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      err_d       = err_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         RUN: begin
            if (mem_pend) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WC_W'(1);
            end
         end
         MEM_WAIT: begin
            // Request dropped without ack is a protocol slip; recover silently.
            if (hz.Mem_ack_i || !hz.Mem_req_i) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WC_W'(TIMEOUT)) begin
               state_d = ERROR;
               err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
      if (!pc_write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // State and counter registers; reset abandons any outstanding access.
   always_ff @(posedge Clock_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   assign hz.PC_write_o      = pc_write;
   assign hz.IF_ID_write_o   = if_id_write;
   assign hz.IF_ID_flush_o   = if_id_flush;
   assign hz.ID_EX_stall_o   = id_ex_stall;
   assign hz.ID_EX_bubble_o  = id_ex_bubble;
   assign hz.EX_MEM_stall_o  = ex_mem_stall;
   assign hz.MEM_WB_bubble_o = mem_wb_bubble;
   assign hz.Stall_count_o   = stall_cnt_q;
   assign hz.Timeout_err_o   = err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl with TIMEOUT=4 and a 2-bit stall counter.
// Single-cycle hazard decode is table-driven; memory wait, watchdog and reset are sequences.
// Inputs change 1ns after posedge; combinational outputs are sampled on the negedge.
module tb_pipeline_hazard_ctrl;
   localparam logic [6:0] NORM   = 7'b1100000;
   localparam logic [6:0] FLUSH  = 7'b1110000;
   localparam logic [6:0] BUBBLE = 7'b0000100;
   localparam logic [6:0] FREEZE = 7'b0001011;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   pipeline_hazard_ctrl_if #(.CNT_W(2)) hz ();

   pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut (
      .Clock_i   (clk),
      .Reset_n_i (rst_n),
      .hz        (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       mr;
      logic [4:0] exrt;
      logic       br;
      logic       req;
      logic       ack;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl [12];

   // Output order: PC_write, IF_ID_write, IF_ID_flush, ID_EX_stall, ID_EX_bubble, EX_MEM_stall, MEM_WB_bubble
   function automatic logic [6:0] outs();
      return {hz.PC_write_o, hz.IF_ID_write_o, hz.IF_ID_flush_o, hz.ID_EX_stall_o,
              hz.ID_EX_bubble_o, hz.EX_MEM_stall_o, hz.MEM_WB_bubble_o};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                         input logic [4:0] exrt, input logic br, input logic req,
                         input logic ack);
      hz.IF_ID_RegRs_i   = rs;
      hz.IF_ID_RegRt_i   = rt;
      hz.ID_EX_MemRead_i = mr;
      hz.ID_EX_RegRt_i   = exrt;
      hz.Branch_taken_i  = br;
      hz.Mem_req_i       = req;
      hz.Mem_ack_i       = ack;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Hold req without ack from RUN: watchdog must trip on exactly the fifth edge.
   task automatic run_timeout(input string tag);
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      repeat (4) tick();
      chk({tag, "_err_before"}, 32'(hz.Timeout_err_o), 32'd0);
      tick();
      chk({tag, "_err_after"}, 32'(hz.Timeout_err_o), 32'd1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      //             rs     rt     mr    exrt   br    req   ack   expected
      tbl[0]  = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, BUBBLE}; // LU on rs
      tbl[1]  = '{5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, BUBBLE}; // LU on rt
      tbl[2]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORM};   // load to r0
      tbl[3]  = '{5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, NORM};   // not a load
      tbl[4]  = '{5'd2, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, FLUSH};  // branch alone
      tbl[5]  = '{5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, BUBBLE}; // LU beats branch
      tbl[6]  = '{5'd5, 5'd7, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, NORM};   // load, no match
      tbl[7]  = '{5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM};   // zero-wait access
      tbl[8]  = '{5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NORM};   // stray ack
      tbl[9]  = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, FREEZE}; // freeze beats LU/branch
      tbl[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM};   // req dropped
      tbl[11] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, FLUSH};  // zero-wait + branch

      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_outs", 32'(outs()), 32'(FREEZE));
      chk("reset_cnt", 32'(hz.Stall_count_o), 32'd0);
      chk("reset_err", 32'(hz.Timeout_err_o), 32'd0);
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         set_in(tbl[i].rs, tbl[i].rt, tbl[i].mr, tbl[i].exrt, tbl[i].br, tbl[i].req, tbl[i].ack);
         @(negedge clk);
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
         tick();
      end
      chk("vec_no_err", 32'(hz.Timeout_err_o), 32'd0);

      // One-cycle load-use stall, then normal flow.
      do_reset();
      set_in(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("lu_outs", 32'(outs()), 32'(BUBBLE));
      tick();
      chk("lu_cnt", 32'(hz.Stall_count_o), 32'd1);
      set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("lu_next", 32'(outs()), 32'(NORM));
      tick();
      chk("lu_cnt_hold", 32'(hz.Stall_count_o), 32'd1);

      // Memory wait: ack arrives 3 cycles after req, with a load-use hazard during freeze.
      do_reset();
      set_in(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("wait%0d", c), 32'(outs()), 32'(FREEZE));
         tick();
      end
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("wait_ack", 32'(outs()), 32'(NORM));
      tick();
      chk("wait_cnt", 32'(hz.Stall_count_o), 32'd3);
      chk("wait_err", 32'(hz.Timeout_err_o), 32'd0);
      set_in(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      tick();
      chk("cnt_sat", 32'(hz.Stall_count_o), 32'd3);

      // Watchdog: ERROR is sticky and ignores a later ack.
      do_reset();
      run_timeout("to");
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("err_ack_only", 32'(outs()), 32'(FREEZE));
      tick();
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("err_req_ack", 32'(outs()), 32'(FREEZE));
      tick();
      chk("err_sticky", 32'(hz.Timeout_err_o), 32'd1);

      // Asynchronous reset mid-MEM_WAIT, then a fresh full watchdog window.
      do_reset();
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      chk("mw_cnt", 32'(hz.Stall_count_o), 32'd2);
      #2;
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_outs", 32'(outs()), 32'(FREEZE));
      chk("arst_cnt", 32'(hz.Stall_count_o), 32'd0);
      chk("arst_err", 32'(hz.Timeout_err_o), 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_run", 32'(outs()), 32'(NORM));
      tick();
      run_timeout("arst_to");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
